// File: rtl/mestpro_pkg.sv
// ---------------------------------------------------------------------------
// mestpro_pkg
// Shared definitions for the MESTPRO instruction sequencer: opcode values
// understood by the downstream accumulator core, program-memory depth and
// word layout, and the sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package mestpro_pkg;

    // Opcodes of the downstream accumulator core. The sequencer itself only
    // cares about OP_HALT; every other value is forwarded untouched.
    localparam logic [7:0] OP_HALT   = 8'd0;
    localparam logic [7:0] OP_LOAD_A = 8'd1;
    localparam logic [7:0] OP_ADD    = 8'd2;
    localparam logic [7:0] OP_SUB    = 8'd3;
    localparam logic [7:0] OP_AND    = 8'd4;
    localparam logic [7:0] OP_OR     = 8'd5;
    localparam logic [7:0] OP_XOR    = 8'd6;
    localparam logic [7:0] OP_OUT    = 8'd7;

    // Program memory geometry
    localparam int PROG_DEPTH = 16;
    localparam int ADDR_W     = 4;

    // One program word: opcode in the upper byte, operand in the lower byte
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] operand;
    } prog_word_t;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mestpro_prog_mem.sv
// ---------------------------------------------------------------------------
// mestpro_prog_mem
// 16 x 16-bit program store for the sequencer. Synchronous write,
// combinational (asynchronous) read. Contents are deliberately not reset so
// a program survives a reset of the sequencer.
//
// Ports:
//   clk      - write clock
//   wr_en    - write enable (qualified by the caller)
//   wr_addr  - write address
//   wr_data  - {opcode, operand} to store
//   rd_addr  - read address
//   rd_data  - {opcode, operand} at rd_addr, combinational
// ---------------------------------------------------------------------------
module mestpro_prog_mem
    import mestpro_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [15:0]         wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [15:0]         rd_data
);

    logic [15:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mestpro_sequencer.sv
// ---------------------------------------------------------------------------
// mestpro_sequencer
// Steps through a small program memory and presents one {opcode, operand}
// pair per cycle to a downstream accumulator core. Execution starts at
// address 0 on START, stalls on PAUSE, and ends on a HALT opcode or after
// the word at the last address has been issued. A one-cycle DONE pulse marks
// completion.
//
// Ports:
//   CLK          - rising-edge clock
//   RESET        - asynchronous active-low reset
//   LOAD_EN      - write one program word (honoured only while idle)
//   LOAD_ADDR    - program write address
//   LOAD_OPCODE  - opcode to store
//   LOAD_OPERAND - operand to store
//   START        - begin execution at address 0 (honoured only while idle)
//   PAUSE        - suppress issue this cycle
//   INSTRUCTION  - registered opcode to the core (0 when nothing is issued)
//   IN_DATA      - registered operand, holds its last issued value
//   BUSY         - high while running
//   DONE         - one-cycle completion pulse
//   PC           - current fetch address
// ---------------------------------------------------------------------------
module mestpro_sequencer
    import mestpro_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD_EN,
    input  logic [3:0]  LOAD_ADDR,
    input  logic [7:0]  LOAD_OPCODE,
    input  logic [7:0]  LOAD_OPERAND,
    input  logic        START,
    input  logic        PAUSE,
    output logic [7:0]  INSTRUCTION,
    output logic [7:0]  IN_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  PC
);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [7:0]        instr;
    logic [7:0]        instr_next;
    logic [7:0]        in_data;
    logic [7:0]        in_data_next;
    logic [15:0]       rd_data;
    prog_word_t        fetch_word;
    logic              mem_wr_en;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

    // Loading is only allowed while idle so a running program never sees its
    // own words change underneath it.
    assign mem_wr_en = LOAD_EN && (state == ST_IDLE);

    mestpro_prog_mem u_prog_mem (
        .clk     (CLK),
        .wr_en   (mem_wr_en),
        .wr_addr (LOAD_ADDR),
        .wr_data ({LOAD_OPCODE, LOAD_OPERAND}),
        .rd_addr (pc),
        .rd_data (rd_data)
    );

    assign fetch_word = prog_word_t'(rd_data);

    // State and datapath registers. The program memory is outside this reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= ST_IDLE;
            pc      <= '0;
            instr   <= 8'd0;
            in_data <= 8'd0;
        end else begin
            state   <= next_state;
            pc      <= pc_next;
            instr   <= instr_next;
            in_data <= in_data_next;
        end
    end

    // Next-state and next-output logic. INSTRUCTION defaults to 0 so that
    // idle, finishing, paused and halting cycles all present a bubble; the
    // operand register simply holds unless a real word is issued. PAUSE is
    // checked before the opcode so a stalled HALT is not acted upon. Issuing
    // the last address lets pc wrap naturally to 0 while the FSM finishes.
    always_comb begin
        next_state   = state;
        pc_next      = pc;
        instr_next   = 8'd0;
        in_data_next = in_data;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    next_state = ST_RUN;
                    pc_next    = '0;
                end
            end
            ST_RUN: begin
                if (!PAUSE) begin
                    if (fetch_word.opcode == OP_HALT) begin
                        next_state = ST_FIN;
                    end else begin
                        instr_next   = fetch_word.opcode;
                        in_data_next = fetch_word.operand;
                        pc_next      = pc + 1'b1;
                        if (pc == LAST_ADDR) begin
                            next_state = ST_FIN;
                        end
                    end
                end
            end
            ST_FIN: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign INSTRUCTION = instr;
    assign IN_DATA     = in_data;
    assign PC          = pc;
    assign BUSY        = (state == ST_RUN);
    assign DONE        = (state == ST_FIN);

endmodule
